// File: rtl/traffic_sensor_interface_if.sv
// Signal bundle between the traffic light controller side and the road sensor front end.
// The master drives detectors and light codes. The slave returns occupancy, counts and fault.
interface traffic_sensor_interface_if #(
    parameter int CNT_W = 4
);
    logic             det_a;
    logic             det_b;
    logic [1:0]       la;
    logic [1:0]       lb;
    logic             ta;
    logic             tb;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             fault;

    modport master (
        output det_a, det_b, la, lb,
        input  ta, tb, cnt_a, cnt_b, fault
    );

    modport slave (
        input  det_a, det_b, la, lb,
        output ta, tb, cnt_a, cnt_b, fault
    );
endinterface

// File: rtl/traffic_sensor_interface.sv
// Road sensor front end: per-road detector sync/debounce, queue counting with timed
// departures on green, occupancy outputs, and a sticky illegal-light-code fault.
module traffic_sensor_interface #(
    parameter int DEB_CYCLES    = 4,
    parameter int DEPART_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input logic                    clk,
    input logic                    reset,
    traffic_sensor_interface_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(DEPART_CYCLES + 1);
    localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]    TMR_LAST = TW'(DEPART_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] GREEN   = 2'b00;
    localparam logic [1:0] RED     = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    logic [1:0]       det;
    logic [1:0]       green;
    logic [CNT_W-1:0] cnt [2];

    assign det   = {bus.det_b, bus.det_a};
    assign green = {bus.lb == GREEN, bus.la == GREEN};

    for (genvar r = 0; r < 2; r++) begin : g_road
        logic             sync1;
        logic             s;
        logic             deb;
        logic [DW-1:0]    deb_cnt;
        logic [TW-1:0]    tmr;
        logic [CNT_W-1:0] count;
        logic             arrival;
        logic             running;
        logic             departure;

        // An arrival is the edge on which the debounced level flips from 0 to 1.
        assign arrival   = s & ~deb & (deb_cnt == DEB_LAST);
        assign running   = green[r] & (count != '0);
        assign departure = running & (tmr == TMR_LAST);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1   <= 1'b0;
                s       <= 1'b0;
                deb     <= 1'b0;
                deb_cnt <= '0;
                tmr     <= '0;
                count   <= '0;
            end else begin
                // NOTE: non-blocking assignments keep every register sampling pre-edge values.
                sync1 <= det[r];
                s     <= sync1;

                if (s != deb) begin
                    if (deb_cnt == DEB_LAST) begin
                        deb     <= ~deb;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end else begin
                    deb_cnt <= '0;
                end

                if (!running || departure) begin
                    tmr <= '0;
                end else begin
                    tmr <= tmr + TW'(1);
                end

                // Simultaneous arrival and departure cancel; a full queue drops arrivals.
                if (arrival && !departure && count != CNT_MAX) begin
                    count <= count + CNT_W'(1);
                end else if (departure && !arrival) begin
                    count <= count - CNT_W'(1);
                end
            end
        end

        assign cnt[r] = count;
    end

    logic fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (bus.la == ILLEGAL || bus.lb == ILLEGAL ||
                     (bus.la != RED && bus.lb != RED)) begin
            fault_q <= 1'b1;
        end
    end

    assign bus.cnt_a = cnt[0];
    assign bus.cnt_b = cnt[1];
    assign bus.ta    = (cnt[0] != '0);
    assign bus.tb    = (cnt[1] != '0);
    assign bus.fault = fault_q;
endmodule

// File: tb/tb_traffic_sensor_interface.sv
// Scoreboard bench for traffic_sensor_interface: directed stimulus queues cycle-stamped
// expected states, and a monitor compares them against the DUT just after each falling edge.
module tb_traffic_sensor_interface;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    traffic_sensor_interface_if #(.CNT_W(CNT_W)) bus ();

    traffic_sensor_interface #(
        .DEB_CYCLES(4),
        .DEPART_CYCLES(8),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    at;
        int    ca;
        int    cb;
        bit    f;
        string tag;
    } exp_t;

    exp_t sb[$];

    // Hand-maintained expected state, updated by the stimulus as scenarios progress.
    int m_a = 0;
    int m_b = 0;
    bit m_f = 1'b0;

    task automatic expect_at(input int at, input int ca, input int cb, input bit f, input string tag);
        exp_t e;
        int   i;
        e.at  = at;
        e.ca  = ca;
        e.cb  = cb;
        e.f   = f;
        e.tag = tag;
        i = sb.size();
        while (i > 0 && sb[i-1].at > at) i--;
        sb.insert(i, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full-length detector pulse; the count changes on the 6th edge after it starts.
    task automatic arrive(input bit road, input int after, input string tag);
        int c;
        c = cyc;
        expect_at(c + 5, m_a, m_b, m_f, {tag, "_pre"});
        if (road == 1'b0) m_a = after; else m_b = after;
        expect_at(c + 6, m_a, m_b, m_f, tag);
        if (road == 1'b0) bus.det_a = 1'b1; else bus.det_b = 1'b1;
        tick(8);
        if (road == 1'b0) bus.det_a = 1'b0; else bus.det_b = 1'b0;
        tick(10);
    endtask

    // Monitor: compare every expectation whose cycle has come due.
    always begin
        exp_t             e;
        logic [CNT_W-1:0] ea;
        logic [CNT_W-1:0] eb;
        @(negedge clk);
        #1;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e  = sb.pop_front();
            ea = CNT_W'(e.ca);
            eb = CNT_W'(e.cb);
            checks++;
            if (e.at != cyc || bus.cnt_a !== ea || bus.cnt_b !== eb ||
                bus.ta !== (ea != '0) || bus.tb !== (eb != '0) || bus.fault !== e.f) begin
                failures++;
                $display("FAIL %s cyc=%0d (due %0d) got ta=%b tb=%b cnt_a=%0d cnt_b=%0d fault=%b expected ta=%b tb=%b cnt_a=%0d cnt_b=%0d fault=%b",
                         e.tag, cyc, e.at, bus.ta, bus.tb, bus.cnt_a, bus.cnt_b, bus.fault,
                         (ea != '0), (eb != '0), ea, eb, e.f);
            end
        end
    end

    initial begin
        int c;
        reset      = 1'b0;
        bus.det_a  = 1'b0;
        bus.det_b  = 1'b0;
        bus.la     = 2'b00;
        bus.lb     = 2'b10;

        // Reset held for three edges, then idle with A green / B red.
        for (int k = 1; k <= 3; k++) expect_at(k, 0, 0, 1'b0, "in_reset");
        tick(3);
        reset = 1'b1;
        c = cyc;
        for (int k = 1; k <= 20; k++) expect_at(c + k, 0, 0, 1'b0, "idle");
        tick(20);

        // Debounced arrival with A red, then a 3-cycle glitch that must be ignored.
        bus.la = 2'b10;
        bus.lb = 2'b00;
        arrive(1'b0, 1, "arrival_a");
        c = cyc;
        bus.det_a = 1'b1;
        tick(3);
        bus.det_a = 1'b0;
        expect_at(c + 10, 1, 0, 1'b0, "glitch_ignored");
        tick(10);

        // Departure rate: 3 -> 2 -> 1 -> 0 at edges 8, 16, 24 after A turns green.
        arrive(1'b0, 2, "build_a2");
        arrive(1'b0, 3, "build_a3");
        c = cyc;
        bus.la = 2'b00;
        bus.lb = 2'b10;
        expect_at(c + 7,  3, 0, 1'b0, "dep1_pre");
        expect_at(c + 8,  2, 0, 1'b0, "dep1");
        expect_at(c + 15, 2, 0, 1'b0, "dep2_pre");
        expect_at(c + 16, 1, 0, 1'b0, "dep2");
        expect_at(c + 23, 1, 0, 1'b0, "dep3_pre");
        expect_at(c + 24, 0, 0, 1'b0, "dep3_ta_fall");
        expect_at(c + 30, 0, 0, 1'b0, "empty_hold");
        tick(30);
        m_a = 0;

        // Yellow interrupts the timer; it restarts from 0 when green returns.
        bus.la = 2'b10;
        bus.lb = 2'b00;
        arrive(1'b0, 1, "refill1");
        arrive(1'b0, 2, "refill2");
        arrive(1'b0, 3, "refill3");
        c = cyc;
        bus.la = 2'b00;
        bus.lb = 2'b10;
        expect_at(c + 7,  3, 0, 1'b0, "y_dep1_pre");
        expect_at(c + 8,  2, 0, 1'b0, "y_dep1");
        expect_at(c + 21, 2, 0, 1'b0, "yellow_hold");
        expect_at(c + 26, 2, 0, 1'b0, "timer_restarted");
        expect_at(c + 28, 2, 0, 1'b0, "y_dep2_pre");
        expect_at(c + 29, 1, 0, 1'b0, "y_dep2");
        expect_at(c + 36, 1, 0, 1'b0, "y_dep3_pre");
        expect_at(c + 37, 0, 0, 1'b0, "y_dep3");
        tick(11);
        bus.la = 2'b01;
        tick(10);
        bus.la = 2'b00;
        tick(20);
        m_a = 0;

        // Arrival lands on a departure edge: count holds at 2.
        bus.la = 2'b10;
        bus.lb = 2'b00;
        arrive(1'b0, 1, "sim_fill1");
        arrive(1'b0, 2, "sim_fill2");
        c = cyc;
        bus.la = 2'b00;
        bus.lb = 2'b10;
        expect_at(c + 7,  2, 0, 1'b0, "sim_pre");
        expect_at(c + 8,  2, 0, 1'b0, "sim_cancel");
        expect_at(c + 15, 2, 0, 1'b0, "sim_next_pre");
        expect_at(c + 16, 1, 0, 1'b0, "sim_next_dep");
        expect_at(c + 24, 0, 0, 1'b0, "sim_drain");
        tick(2);
        bus.det_a = 1'b1;
        tick(8);
        bus.det_a = 1'b0;
        tick(20);
        m_a = 0;

        // Saturation: 16 arrivals with A red, the 16th is dropped.
        bus.la = 2'b10;
        bus.lb = 2'b00;
        for (int i = 1; i <= 16; i++) arrive(1'b0, (i < 15) ? i : 15, $sformatf("sat_%0d", i));

        // Road B: six arrivals while yellow, then one departure on green.
        bus.lb = 2'b01;
        for (int i = 1; i <= 6; i++) arrive(1'b1, i, $sformatf("b_arr_%0d", i));
        c = cyc;
        bus.lb = 2'b00;
        expect_at(c + 7, 15, 6, 1'b0, "b_dep_pre");
        expect_at(c + 8, 15, 5, 1'b0, "b_dep");
        tick(8);
        bus.lb = 2'b01;
        m_b = 5;

        // Neither road red for one cycle sets the sticky fault without disturbing counts.
        c = cyc;
        bus.la = 2'b00;
        bus.lb = 2'b01;
        expect_at(c,     15, 5, 1'b0, "fault_pre");
        expect_at(c + 1, 15, 5, 1'b1, "fault_set");
        expect_at(c + 6, 15, 5, 1'b1, "fault_sticky");
        tick(1);
        bus.la = 2'b10;
        tick(6);

        // Asynchronous reset mid-operation clears queues and fault at once.
        c = cyc;
        reset = 1'b0;
        expect_at(c,     0, 0, 1'b0, "reset_immediate");
        expect_at(c + 1, 0, 0, 1'b0, "reset_held");
        tick(2);
        reset = 1'b1;
        bus.la = 2'b11;
        bus.lb = 2'b10;
        expect_at(c + 2, 0, 0, 1'b0, "la_illegal_pre");
        expect_at(c + 3, 0, 0, 1'b1, "la_illegal");
        tick(1);
        bus.lb = 2'b00;
        bus.la = 2'b10;
        tick(3);

        c = cyc;
        reset = 1'b0;
        expect_at(c, 0, 0, 1'b0, "reset_clears_fault");
        tick(1);
        reset = 1'b1;
        bus.la = 2'b10;
        bus.lb = 2'b11;
        expect_at(c + 1, 0, 0, 1'b0, "lb_illegal_pre");
        expect_at(c + 2, 0, 0, 1'b1, "lb_illegal");
        tick(1);
        bus.lb = 2'b00;
        tick(3);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        #2;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/traffic_sensor_interface.md
Name: traffic_sensor_interface

Overview:
Road-side sensor front end that produces the ta/tb occupancy inputs for the two-road traffic light controller. It consumes that controller's la/lb light codes.
- For each road, it debounces a raw vehicle detector.
- It counts queued vehicles: arrivals add to the queue, and vehicles leave at a fixed rate while that road's light is green.
- It asserts ta/tb while the corresponding queue is non-empty.
- It also checks the light codes for illegal combinations and flags a sticky fault.

Parameters:
DEB_CYCLES, 4, consecutive cycles a synchronized detector level must differ from the debounced level before the debounced level changes (>=1).
DEPART_CYCLES, 8, green cycles with a non-empty queue per vehicle departure (>=1).
CNT_W, 4, queue counter width; queue saturates at 2^CNT_W-1.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
det_a  input  1  raw, asynchronous vehicle detector, road A (1 = vehicle present).
det_b  input  1  raw, asynchronous vehicle detector, road B.
la  input  2  road A light code from controller: 00 green, 01 yellow, 10 red, 11 illegal.
lb  input  2  road B light code, same encoding.
ta  output  1  road A queue non-empty.
tb  output  1  road B queue non-empty.
cnt_a  output  CNT_W  road A queued-vehicle count.
cnt_b  output  CNT_W  road B queued-vehicle count.
fault  output  1  sticky light-code fault.

Behaviour:
Reset:
- While reset=0, all state clears asynchronously: synchronizers, debounced levels, debounce counters, departure timers, cnt_a, cnt_b, fault.
- So ta=tb=0, cnt_a=cnt_b=0, fault=0.
- Reset asserted mid-operation discards queues and fault immediately. No arrival is counted for a detector already high at reset release until it has been debounced high from the cleared state.

Per road (A shown; B identical with det_b/lb/cnt_b/tb):
Synchronization:
- det_a passes through a 2-flop synchronizer, giving s_a.
Debouncing:
- Debounced level deb_a has a counter.
- On each edge where s_a != deb_a, the counter increments.
- On each edge where s_a == deb_a, the counter clears.
- When the counter would reach DEB_CYCLES, deb_a toggles and the counter clears.
Arrival:
- Arrival is the edge on which deb_a goes 0->1.
- Latency: when det_a is held high from the first edge that samples it (edge 1), cnt_a increments on edge DEB_CYCLES+2. With defaults, that is edge 6.
- Falling debounce produces no event.
- A pulse shorter than DEB_CYCLES synchronized cycles is ignored.
Departure timer:
- Runs only on edges where la==00 and cnt_a!=0.
- If the timer == DEPART_CYCLES-1, that edge is a departure and the timer resets to 0; otherwise the timer increments.
- On any edge where la!=00 or cnt_a==0, the timer is held at 0.
- The first departure occurs on the DEPART_CYCLES-th consecutive qualifying edge.
- Yellow (01) and red (10) give no departures.
Count update, per edge:
- Arrival only: +1, saturating at 2^CNT_W-1; the arrival is dropped at saturation.
- Departure only: -1. A departure never occurs at 0.
- Arrival and departure on the same edge: unchanged, and the timer still resets.
Occupancy output:
- ta = (cnt_a != 0), combinational from the count register.
- ta rises on the same edge as the first counted arrival and falls on the edge of the last departure.
Fault:
- On each edge, fault sets if la==11, lb==11, or (la!=10 and lb!=10).
- The last condition means the two roads are not both safe: at least one must be red.
- fault stays set until reset.
- The fault check does not alter counting.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release, det_a=det_b=0, la=00, lb=10 for 20 cycles -> ta=tb=0, cnt_a=cnt_b=0, fault=0 throughout.
- Debounced arrival: det_a high from edge 1, la=10, lb=00 (A red, no departures) -> cnt_a 0->1 and ta 0->1 exactly at edge 6. A 3-cycle det_a glitch -> cnt_a unchanged.
- Departure rate: cnt_a=3, la switched to 00 -> cnt_a 3->2->1->0 at edges 8, 16, 24 after the switch; ta falls at edge 24. Switching la to 01 at edge 12 -> cnt_a holds at 2, and the timer restarts from 0 when la returns to 00.
- Simultaneous events: cnt_a=2, la=00, debounced arrival landing on a departure edge -> cnt_a stays 2.
- Saturation: CNT_W=4, 16 separated arrivals with A red -> cnt_a=15 after 15 arrivals, 16th dropped, still 15.
- Fault and reset mid-operation: la=00, lb=01 for 1 cycle -> fault=1 next edge and stays 1. Also la=11 alone sets fault. Pulling reset low with cnt_b=5 -> cnt_b=0, tb=0, fault=0 immediately.
